// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared definitions for the systolic MAC array
// Purpose: FSM state encoding, default widths and the saturating add used by
//          the processing elements when ACC_SAT_EN is defined.
// Ports: none (package).
package systolic_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_LOAD  = 2'd1;
  localparam state_t S_FLUSH = 2'd2;
  localparam state_t S_DRAIN = 2'd3;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 32;
  localparam int KW_DEF = 16;

  // Adds two sign-extended values and clamps the result to the signed range
  // of an aw-bit accumulator. One guard bit keeps the raw sum exact.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] addend,
                                                 input int aw);
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = 65'(acc) + 65'(addend);
    hi  = (65'sd1 <<< (aw - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (aw - 1));
    if (sum > hi) begin
      sat_add = hi[63:0];
    end else if (sum < lo) begin
      sat_add = lo[63:0];
    end else begin
      sat_add = sum[63:0];
    end
  endfunction

endpackage

// File: rtl/systolic_mac_array_if.sv
// rtl/systolic_mac_array_if.sv - control, operand and result bundle of the MAC array
// Purpose: groups run control, the a/w operand stream and the result row stream.
// Signals: start, k_len (run control); in_valid/in_ready/in_a/in_w (operand beats);
//          out_valid/out_ready/out_data (result rows); busy, done (status).
// Modports: master = feeder/consumer side, slave = array side.
interface systolic_mac_array_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32,
  parameter int KW   = 16
);
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_a;
  logic [COLS*DW-1:0]   in_w;
  logic                 out_valid;
  logic                 out_ready;
  logic [COLS*AW-1:0]   out_data;
  logic                 busy;
  logic                 done;

  modport master (
    output start, k_len, in_valid, in_a, in_w, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_a, in_w, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one output-stationary MAC cell
// Purpose: forwards a to the right and w downward (each with its valid bit)
//          and accumulates sext(a)*sext(w) on a valid beat. ACC_SAT_EN selects
//          saturating accumulation; otherwise the accumulator wraps.
// Ports: clk, rst (sync, active-high), clr (zero the accumulator),
//        a_in/a_vin, w_in/w_vin (operands from left/above),
//        a_out/a_vout, w_out/w_vout (registered forwards), acc (accumulator).
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic          a_vin,
  input  logic [DW-1:0] w_in,
  input  logic          w_vin,
  output logic [DW-1:0] a_out,
  output logic          a_vout,
  output logic [DW-1:0] w_out,
  output logic          w_vout,
  output logic [AW-1:0] acc
);

  logic signed [2*DW-1:0] a_x;
  logic signed [2*DW-1:0] w_x;
  logic signed [2*DW-1:0] prod;
  logic        [AW-1:0]   acc_d;

  // Operands are widened first so the product is exact at 2*DW bits.
  assign a_x  = (2*DW)'($signed(a_in));
  assign w_x  = (2*DW)'($signed(w_in));
  assign prod = a_x * w_x;

`ifdef ACC_SAT_EN
  assign acc_d = AW'(sat_add(64'($signed(acc)), 64'(prod), AW));
`else
  logic signed [AW-1:0] prod_ext;
  assign prod_ext = AW'(prod);
  assign acc_d    = acc + prod_ext;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out  <= '0;
      a_vout <= 1'b0;
      w_out  <= '0;
      w_vout <= 1'b0;
      acc    <= '0;
    end else begin
      a_out  <= a_in;
      a_vout <= a_vin;
      w_out  <= w_in;
      w_vout <= w_vin;
      if (clr) begin
        acc <= '0;
      end else if (a_vin && w_vin) begin
        acc <= acc_d;
      end
    end
  end

endmodule

// File: rtl/systolic_mac_array.sv
// rtl/systolic_mac_array.sv - output-stationary systolic MAC array with streaming load and drain
// Purpose: computes C[r][c] = sum_k a_k[r]*w_k[c] over k_len beats, then drains
//          C row by row with backpressure. Optional macro ACC_SAT_EN makes the
//          accumulators saturate instead of wrapping.
// Ports: clk, rst (sync, active-high), bus (systolic_mac_array_if.slave):
//        start/k_len, in_valid/in_ready/in_a/in_w, out_valid/out_ready/out_data,
//        busy, done.
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int KW   = KW_DEF
) (
  input logic clk,
  input logic rst,
  systolic_mac_array_if.slave bus
);

  localparam int FW = $clog2(ROWS + COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [KW-1:0]     k_q;
  logic [KW-1:0]     beat_q;
  logic [FW-1:0]     flush_q;
  logic [RW-1:0]     row_q;
  logic [RW-1:0]     row_sel;
  logic              out_valid_q;
  logic              done_q;
  logic [COLS*AW-1:0] out_data_q;
  logic [COLS*AW-1:0] row_data;

  logic beat_acc;
  logic clr;
  logic hs;
  logic last_row;
  logic last_beat;
  logic flush_end;

  assign beat_acc  = bus.in_valid && (state_q == S_LOAD);
  assign clr       = bus.start && (state_q == S_IDLE);
  assign hs        = out_valid_q && bus.out_ready;
  assign last_row  = (row_q == RW'(ROWS - 1));
  assign last_beat = (beat_q == k_q - KW'(1));
  assign flush_end = (flush_q == FW'(ROWS + COLS - 2));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (bus.k_len != '0) ? S_LOAD : S_DRAIN;
      S_LOAD:  if (beat_acc && last_beat) state_d = S_FLUSH;
      S_FLUSH: if (flush_end) state_d = S_DRAIN;
      S_DRAIN: if (hs && last_row) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == S_LOAD);
    bus.busy     = (state_q != S_IDLE);
  end

  // ---------------- counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      if (clr) begin
        k_q    <= bus.k_len;
        beat_q <= '0;
      end else if (beat_acc) begin
        beat_q <= beat_q + KW'(1);
      end
      flush_q <= (state_q == S_FLUSH) ? flush_q + FW'(1) : '0;
    end
  end

  // ---------------- input skew ----------------
  logic [ROWS*DW-1:0] a_edge;
  logic [ROWS-1:0]    av_edge;
  logic [COLS*DW-1:0] w_edge;
  logic [COLS-1:0]    wv_edge;

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign a_edge[DW-1:0] = bus.in_a[DW-1:0];
      assign av_edge[0]     = beat_acc;
    end else begin : g_delay
      localparam int DEPTH = r;
      logic [DEPTH*DW-1:0] d_sr;
      logic [DEPTH-1:0]    v_sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          d_sr <= '0;
          v_sr <= '0;
        end else begin
          d_sr <= (d_sr << DW) | (DEPTH*DW)'(bus.in_a[r*DW +: DW]);
          v_sr <= (v_sr << 1) | DEPTH'(beat_acc);
        end
      end
      assign a_edge[r*DW +: DW] = d_sr[DEPTH*DW-1 -: DW];
      assign av_edge[r]         = v_sr[DEPTH-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_w_skew
    if (c == 0) begin : g_direct
      assign w_edge[DW-1:0] = bus.in_w[DW-1:0];
      assign wv_edge[0]     = beat_acc;
    end else begin : g_delay
      localparam int DEPTH = c;
      logic [DEPTH*DW-1:0] d_sr;
      logic [DEPTH-1:0]    v_sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          d_sr <= '0;
          v_sr <= '0;
        end else begin
          d_sr <= (d_sr << DW) | (DEPTH*DW)'(bus.in_w[c*DW +: DW]);
          v_sr <= (v_sr << 1) | DEPTH'(beat_acc);
        end
      end
      assign w_edge[c*DW +: DW] = d_sr[DEPTH*DW-1 -: DW];
      assign wv_edge[c]         = v_sr[DEPTH-1];
    end
  end

  // ---------------- PE grid ----------------
  // a travels along a_h[r][*] to the right, w along w_v[*][c] downward; the
  // extra last column/row catch the forwards leaving the array edge.
  logic [DW-1:0] a_h  [ROWS][COLS+1];
  logic          av_h [ROWS][COLS+1];
  logic [DW-1:0] w_v  [ROWS+1][COLS];
  logic          wv_v [ROWS+1][COLS];
  logic [AW-1:0] acc_g [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign a_h[r][0]  = a_edge[r*DW +: DW];
    assign av_h[r][0] = av_edge[r];
    logic unused_a;
    assign unused_a = ^{a_h[r][COLS], av_h[r][COLS]};
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .a_in   (a_h[r][c]),
        .a_vin  (av_h[r][c]),
        .w_in   (w_v[r][c]),
        .w_vin  (wv_v[r][c]),
        .a_out  (a_h[r][c+1]),
        .a_vout (av_h[r][c+1]),
        .w_out  (w_v[r+1][c]),
        .w_vout (wv_v[r+1][c]),
        .acc    (acc_g[r][c])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wtop
    assign w_v[0][c]  = w_edge[c*DW +: DW];
    assign wv_v[0][c] = wv_edge[c];
    logic unused_w;
    assign unused_w = ^{w_v[ROWS][c], wv_v[ROWS][c]};
  end

  // ---------------- drain ----------------
  // On a handshake the next row is loaded in the same edge, so rows stream
  // back-to-back when the consumer is always ready.
  always_comb begin
    row_sel  = (hs && !last_row) ? row_q + RW'(1) : row_q;
    row_data = '0;
    for (int c = 0; c < COLS; c++) begin
      row_data[c*AW +: AW] = acc_g[row_sel][c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      row_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_DRAIN) begin
        if (!out_valid_q) begin
          // First drain cycle: accumulators are final (also covers k_len==0,
          // where they were cleared on the start edge).
          out_valid_q <= 1'b1;
          out_data_q  <= row_data;
        end else if (bus.out_ready) begin
          if (last_row) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            row_q       <= '0;
          end else begin
            row_q      <= row_q + RW'(1);
            out_data_q <= row_data;
          end
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;

endmodule
